pem_edge_conditioner: RTL and testbench

PEM_EDGE_CONDITIONER -- requirements
Module: pem_edge_conditioner

---
 rtl/pem_edge_conditioner.sv | 144 ++++++++++++++
 tb/tb_pem_edge_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pem_edge_conditioner.sv
// PEM reference conditioner: 2-flop sync, deglitch, edge lockout, LOS detect.
// In: clk, rst_n, pem_ref_in, enable. Out: pem_posedge, pem_level, period,
// period_valid, signal_lost. Macro PEM_PERIOD_MEAS_EN enables period output.
module pem_edge_conditioner #(
  parameter int unsigned GLITCH_CYC  = 8,
  parameter int unsigned MIN_PERIOD  = 16,
  parameter logic [19:0] LOS_TIMEOUT = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pem_ref_in,
  input  logic        enable,
  output logic        pem_posedge,
  output logic        pem_level,
  output logic [19:0] period,
  output logic        period_valid,
  output logic        signal_lost
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCK,
    S_LOST
  } state_t;

  localparam logic [7:0]  GLAST = 8'(GLITCH_CYC - 1);
  localparam logic [19:0] MINP  = 20'(MIN_PERIOD);
  localparam logic [19:0] LLAST = LOS_TIMEOUT - 20'd1;
  localparam logic [19:0] SMAX  = 20'hFFFFF;

  logic        r_s1;
  logic        r_s2;
  logic        r_level;
  logic        r_level_d;
  logic        r_cand;
  logic [7:0]  r_gcnt;
  logic [19:0] r_since;
  state_t      r_state;
  logic        r_pulse;
  logic        r_lost;

  state_t      w_next;
  logic        w_acc;
  logic        w_clear;

  // r_cand adds one stage so the pulse lands GLITCH_CYC+3 after the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cand    <= 1'b0;
      r_gcnt    <= '0;
    end else begin
      r_s1      <= pem_ref_in;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      r_cand    <= r_level & ~r_level_d;
      if (r_s2 == r_level) begin
        r_gcnt <= '0;
      end else if (r_gcnt == GLAST) begin
        r_gcnt  <= '0;
        r_level <= r_s2;
      end else begin
        r_gcnt <= r_gcnt + 8'd1;
      end
    end
  end

  // r_since holds the distance (in cycles) to the last accepted edge.
  assign w_clear = (r_since > MINP);

  always_comb begin
    w_acc  = 1'b0;
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_ACQ;
      S_ACQ: begin
        w_acc = r_cand;
        if (r_cand) w_next = S_LOCK;
      end
      S_LOCK: begin
        w_acc = r_cand & w_clear;
        if (!w_acc && r_since == LLAST)
          w_next = S_LOST;
      end
      S_LOST: begin
        w_acc = r_cand & w_clear;
        if (w_acc) w_next = S_LOCK;
      end
      default: w_next = S_IDLE;
    endcase
    if (!enable) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_since <= '0;
      r_pulse <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pulse <= w_acc;
      r_lost  <= (r_state == S_LOST);
      if (r_state == S_IDLE)
        r_since <= '0;
      else if (w_acc)
        r_since <= 20'd1;
      else if (r_since != SMAX)
        r_since <= r_since + 20'd1;
    end
  end

  assign pem_posedge = r_pulse;
  assign pem_level   = r_level;
  assign signal_lost = r_lost;

`ifdef PEM_PERIOD_MEAS_EN
  logic [19:0] r_period;
  logic        r_pv;

  // Only edges seen while already locked have a meaningful predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_pv     <= 1'b0;
    end else begin
      r_pv <= w_acc & (r_state == S_LOCK);
      if (w_acc && r_state == S_LOCK)
        r_period <= r_since;
    end
  end

  assign period       = r_period;
  assign period_valid = r_pv;
`else
  assign period       = 20'd0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pem_edge_conditioner.sv
// Randomized + directed bench for pem_edge_conditioner.
// Event-level reference model, per-cycle compare, literal scenario checks.
module tb_pem_edge_conditioner;

  localparam int G  = 8;
  localparam int MP = 16;
  localparam logic [19:0] LT = 20'd1000;
  localparam int LAT = 11;

  logic        clk;
  logic        rst_n;
  logic        pem_ref_in;
  logic        enable;
  logic        pem_posedge;
  logic        pem_level;
  logic [19:0] period;
  logic        period_valid;
  logic        signal_lost;

  pem_edge_conditioner #(
    .GLITCH_CYC (G),
    .MIN_PERIOD (MP),
    .LOS_TIMEOUT(LT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pem_ref_in  (pem_ref_in),
    .enable      (enable),
    .pem_posedge (pem_posedge),
    .pem_level   (pem_level),
    .period      (period),
    .period_valid(period_valid),
    .signal_lost (signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec rules on edge indices, not on RTL registers.
  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_LOST = 3;

  logic        e_pulse, e_pv, e_lost, e_lev;
  logic [19:0] e_period;

  initial begin
    int n, last, mst, pre;
    logic x1, x2, s2, flip, rise, cand, acc;
    logic [1:0] rp;
    logic [255:0] hist;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; last = 0; mst = M_IDLE;
        x1 = 0; x2 = 0; rp = 0; hist = '0;
        e_pulse = 0; e_pv = 0; e_lost = 0; e_lev = 0; e_period = 0;
      end else begin
        n++;
        s2 = x2; x2 = x1; x1 = pem_ref_in;
        hist = {hist[254:0], s2};
        flip = 1'b1;
        for (int i = 0; i < G; i++)
          if (hist[i] == e_lev) flip = 1'b0;
        rise = flip & ~e_lev;
        if (flip) e_lev = ~e_lev;
        cand = rp[1];
        rp = {rp[0], rise};
        pre = mst;
        acc = cand && pre != M_IDLE &&
              (pre == M_ACQ || (n - last) > MP);
        e_pulse = acc;
        e_lost  = (pre == M_LOST);
`ifdef PEM_PERIOD_MEAS_EN
        e_pv = acc && pre == M_LOCK;
        if (e_pv) e_period = 20'(n - last);
`else
        e_pv = 0;
`endif
        if (pre == M_IDLE) mst = M_ACQ;
        else if (acc) mst = M_LOCK;
        else if (pre == M_LOCK && (n - last) == int'(LT) - 1) mst = M_LOST;
        if (acc) last = n;
        if (!enable) mst = M_IDLE;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("posedge", pem_posedge, e_pulse);
    chk("pv", period_valid, e_pv);
    chk("period", period, e_period);
    chk("lost", signal_lost, e_lost);
    chk("level", pem_level, e_lev);
  end

  int np, npv, k, m;

  task automatic run(input logic v, input int cyc);
    pem_ref_in = v;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (pem_posedge) begin
        np++;
        if (period_valid) npv++;
      end
    end
  endtask

  task automatic wait_pulse(output int cnt);
    cnt = 0;
    pem_ref_in = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
    end while (!pem_posedge && cnt < 200);
    chk("pulse_seen", pem_posedge, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; enable = 0; pem_ref_in = 0;
    np = 0; npv = 0;
    repeat (3) @(negedge clk);
    chk("rst_level", pem_level, 0);
    chk("rst_period", period, 0);
    chk("rst_lost", signal_lost, 0);
    rst_n = 1;
    enable = 1;
    run(0, 20);

    // S1: 100-cycle square, latency then steady period.
    wait_pulse(k);
    chk("latency", k - 1, LAT);
    run(1, 50 - k);
    np = 0; npv = 0;
    for (int i = 0; i < 5; i++) begin
      run(0, 50);
      run(1, 50);
    end
    chk("s1_pulses", np, 5);
`ifdef PEM_PERIOD_MEAS_EN
    chk("s1_pv", npv, 5);
    chk("s1_period", period, 100);
`else
    chk("s1_pv_off", npv, 0);
    chk("s1_period_off", period, 0);
`endif
    chk("s1_lost", signal_lost, 0);
    run(0, 60);

    // S2: 5-cycle glitch is rejected.
    np = 0;
    run(1, 5);
    run(0, 100);
    chk("s2_pulses", np, 0);
    chk("s2_level", pem_level, 0);

    // S3: edge 16 cycles after accepted edge is locked out.
    np = 0;
    run(1, 8); run(0, 8); run(1, 8); run(0, 76);
    run(1, 50); run(0, 50);
    chk("s3_pulses", np, 2);
`ifdef PEM_PERIOD_MEAS_EN
    chk("s3_period", period, 100);
`endif

    // S4: loss of signal after LT cycles, recovery edge.
    wait_pulse(k);
    pem_ref_in = 0;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!signal_lost && m < 1200);
    chk("s4_los_time", m, 1000);
    run(0, 30);
    wait_pulse(k);
    chk("s4_pv_on_recover", period_valid, 0);
    chk("s4_lost_at_pulse", signal_lost, 1);
    @(negedge clk);
    chk("s4_lost_clear", signal_lost, 0);
    run(1, 40);
    run(0, 50);

    // S5: disabled square wave, then re-enable.
    enable = 0;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      run(1, 50);
      run(0, 50);
    end
    chk("s5_pulses_off", np, 0);
    enable = 1;
    run(0, 10);
    wait_pulse(k);
    chk("s5_pv_first", period_valid, 0);
    run(1, 40);
    run(0, 50);

    // Random runs with occasional enable toggles.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      run(logic'(i % 2), $urandom_range(1, 60));
    end
    enable = 1;
    run(0, 60);

    // S6: async reset during a pulse.
    wait_pulse(k);
    #2 rst_n = 0;
    #1;
    chk("s6_posedge", pem_posedge, 0);
    chk("s6_level", pem_level, 0);
    chk("s6_period", period, 0);
    chk("s6_pv", period_valid, 0);
    chk("s6_lost", signal_lost, 0);
    @(negedge clk);
    rst_n = 1;
    run(0, 30);
    for (int i = 0; i < 2; i++) begin
      run(1, 50);
      run(0, 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
